// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, default operand width and counter-width helper.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH = 8;
  localparam int SA_CNT_W = $clog2(SA_WIDTH);

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder assembled from two half adders and an OR of their
// carries. This is the single arithmetic cell that the serial controller
// reuses once per operand bit.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.x(a),  .y(b),  .s(s1), .c(c1));
  half_adder u_ha1 (.x(s1), .y(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. Operands are captured on accept and
// fed LSB first through one full-adder cell, one bit per clock; the completed
// sum and carry are registered and held until the next completion.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a SUB input that turns the
// operation into A - B (B inverted, carry-in forced to 1).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-2:0] psum;
  logic             carry;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] psum_nx;
  logic [WIDTH-1:0] opb_load;
  logic             carry_load;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign last_bit = (cnt == LAST);
  // The partial sum keeps WIDTH-1 bits; the incoming cell bit completes it.
  assign psum_nx  = {fa_s, psum};

  serial_fa_cell u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Operand and carry values loaded on accept (inverted B and carry 1 for subtract).
  always_comb begin
    opb_load   = b;
    carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      opb_load   = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Datapath: operand capture, serial shifting, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      opa   <= a;
      opb   <= opb_load;
      psum  <= '0;
      carry <= carry_load;
    end else if (state == S_RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      psum  <= psum_nx[WIDTH-1:1];
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum  <= psum_nx;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8). Expected
// values are hand-computed constants.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Count DONE-high cycles seen at each rising edge.
  always @(posedge clk) if (done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for DONE with a bound; returns cycles waited and busy-high cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      step();
      lat++;
    end
  endtask

  // Launch one operation from IDLE and check latency, busy span and result.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    int bcnt;
    a = av; b = bv; cin = ci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sb;
`endif
    step();
    start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int lat;
    int bcnt;
    int pulses0;

    // Reset state.
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Basic adds, including carry-out cases.
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // START and A changed mid-RUN are ignored: 0x21 + 0x13 = 0x34.
    pulses0 = done_pulses;
    a = 8'h21; b = 8'h13; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; a = 8'hF0;
    step();
    start = 1'b0; b = 8'h77; cin = 1'b1;
    wait_done(lat, bcnt);
    check("midrun_latency", 32'(lat + 4), 32'd8);
    check("midrun_sum", 32'(sum), 32'h34);
    check("midrun_cout", 32'(cout), 32'd0);
    step(); step(); step();
    check("midrun_single_done", 32'(done_pulses - pulses0), 32'd1);
    check("midrun_back_idle", 32'(busy), 32'd0);

    // Reset during RUN: abandoned, outputs cleared, no DONE.
    pulses0 = done_pulses;
    a = 8'h44; b = 8'h44; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_sum", 32'(sum), 32'd0);
    check("rst_run_cout", 32'(cout), 32'd0);
    check("rst_run_done", 32'(done), 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("rst_run_no_done", 32'(done_pulses - pulses0), 32'd0);
    run_op("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);

    // Back-to-back with START held high: DONE pulses 9 cycles apart.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h10; b = 8'h20;
    wait_done(lat, bcnt);
    check("b2b_first_latency", 32'(lat), 32'd8);
    check("b2b_first_sum", 32'(sum), 32'h03);
    step();
    wait_done(lat, bcnt);
    start = 1'b0;
    check("b2b_spacing", 32'(lat + 1), 32'd9);
    check("b2b_second_sum", 32'(sum), 32'h30);
    check("b2b_second_cout", 32'(cout), 32'd0);
    step();
    check("b2b_idle_done", 32'(done), 32'd0);
    check("b2b_idle_busy", 32'(busy), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("sub0_add", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller that sequences a single one-bit full-adder cell, built from two half-adder stages plus an OR, over WIDTH clock cycles, LSB first. It trades latency for area: one adder cell replaces a WIDTH-bit ripple chain. It sits between a requesting datapath and the shared half-adder resource, with a START/DONE handshake and a stable registered result.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request; sampled only when accepting (state IDLE or DONE)
- A  input  WIDTH  operand A, captured on accept
- B  input  WIDTH  operand B, captured on accept
- CIN  input  1  carry-in, captured on accept
- SUB  input  1  subtract request, captured on accept (present only with SERIAL_ADDER_SUB_EN)
- BUSY  output  1  high while in RUN
- DONE  output  1  one-cycle pulse, result just updated
- SUM  output  WIDTH  registered result, held until next completion
- COUT  output  1  registered carry-out, held with SUM

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: BUSY=0, DONE=0, SUM=0, COUT=0, bit counter=0, internal shift registers=0.
- IDLE: START=1 → capture A, B, CIN into shift registers and the carry flop; counter=0; → RUN. START=0 → stay.
- RUN, each cycle:
  - Full-adder cell takes opA[0], opB[0] and the carry flop.
  - Sum bit shifts into the MSB of the partial-sum register, which shifts right.
  - opA and opB shift right; carry flop takes the cell carry.
  - Counter increments.
  - On the cycle with counter == WIDTH-1: load SUM from the completed partial sum and COUT from the final carry; → DONE.
- DONE: DONE=1 for exactly one cycle. START=1 → accept a new operation (same capture as IDLE) and go to RUN. Otherwise → IDLE.
- START in RUN is ignored; there is no queueing. A, B and CIN changing during RUN have no effect.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1). No overflow flag.
- RST_N low in any state returns to IDLE immediately. The operation is abandoned, outputs go to reset values, and no DONE pulse is issued.

## Timing
- START accepted at edge 0 → BUSY=1 after edge 0.
- Bits 0..WIDTH-1 are processed at edges 1..WIDTH. SUM/COUT update and DONE=1 after edge WIDTH; BUSY=0 in the same cycle.
- Latency from accept to DONE: WIDTH cycles.
- Back-to-back throughput: one operation per WIDTH+1 cycles, with START held high through DONE.
- DONE and BUSY are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - SUB port exists.
  - On accept with SUB=1: B is captured bit-inverted and the carry flop is forced to 1, so the result is A − B; CIN is ignored.
  - COUT=1 means no borrow.
  - SUB=0 behaves as add.
- SERIAL_ADDER_SUB_EN undefined: SUB port and inversion logic are absent; add only.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - counter width as $clog2(WIDTH)
- Sub-module serial_fa_cell: combinational one-bit full adder built from two half-adder instances plus an OR on their carries. The controller instantiates it once.
- Controller holds the FSM, counter, operand and partial-sum shift registers, carry flop, and result registers.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, CIN=0 → DONE 8 cycles after accept, SUM=0x96, COUT=0, BUSY high exactly 8 cycles.
- A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1. A=0xFF, B=0xFF, CIN=1 → SUM=0xFF, COUT=1.
- START pulsed at cycle 3 of RUN, and A changed mid-RUN → ignored; result matches the originally captured operands; a single DONE pulse.
- RST_N low during cycle 4 of RUN → BUSY=0, SUM=0, COUT=0, no DONE. A new START after release → correct result.
- START held high continuously with A=0x01, B=0x02 then A=0x10, B=0x20 → DONE pulses spaced 9 cycles apart, SUM=0x03 then 0x30.
- With SERIAL_ADDER_SUB_EN: A=0x10, B=0x01, SUB=1 → SUM=0x0F, COUT=1. A=0x01, B=0x02, SUB=1 → SUM=0xFF, COUT=0.
